// File: rtl/ctr_ks_gen_pkg.sv
// Shared types and helpers for the CTR keystream generator: block width,
// keystream slot record, run-state encoding and the low-field counter step.
package ctr_ks_gen_pkg;

  localparam int BLOCK_W       = 128;
  localparam int INC_WIDTH_DEF = 32;

  typedef enum logic {
    ST_UNLOADED = 1'b0,
    ST_RUN      = 1'b1
  } ctr_state_e;

  typedef struct packed {
    logic               valid;
    logic [BLOCK_W-1:0] data;
  } ks_slot_t;

  // Increment only the low inc_w bits; the upper field never sees a carry.
  function automatic logic [BLOCK_W-1:0] inc32(input logic [BLOCK_W-1:0] blk,
                                               input int unsigned        inc_w);
    logic [BLOCK_W-1:0] mask;
    mask = {BLOCK_W{1'b1}} >> (BLOCK_W - inc_w);
    return (blk & ~mask) | ((blk + 128'd1) & mask);
  endfunction

endpackage

// File: rtl/ctr_ks_gen_ks_slot_fifo.sv
// Two-entry keystream shift queue: slot0 is the presented block, slot1 the
// prefetched one. A pop and a push in the same cycle never lose or duplicate.
module ctr_ks_gen_ks_slot_fifo
  import ctr_ks_gen_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [BLOCK_W-1:0] push_data_i,
  input  logic               pop_i,
  output ks_slot_t           slot0_o,
  output ks_slot_t           slot1_o
);

  ks_slot_t slot0_q, slot0_d;
  ks_slot_t slot1_q, slot1_d;
  ks_slot_t shift0_s, shift1_s;

  // Next slot contents: apply the pop first, then drop the push into the first hole.
  always_comb begin
    shift0_s = slot0_q;
    shift1_s = slot1_q;
    if (pop_i) begin
      shift0_s = slot1_q;
      shift1_s = '0;
    end else begin
      shift0_s = slot0_q;
    end

    slot0_d = shift0_s;
    slot1_d = shift1_s;
    if (flush_i) begin
      slot0_d = '0;
      slot1_d = '0;
    end else if (push_i) begin
      if (!shift0_s.valid) begin
        slot0_d = '{valid: 1'b1, data: push_data_i};
      end else begin
        slot1_d = '{valid: 1'b1, data: push_data_i};
      end
    end else begin
      slot0_d = shift0_s;
    end
  end

  // Slot storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign slot0_o = slot0_q;
  assign slot1_o = slot1_q;

endmodule

// File: rtl/ctr_ks_gen.sv
// CTR keystream responder: steps the counter, issues blocks to the AES core one
// at a time, and serves results to the XOR stage through a two-slot queue.
module ctr_ks_gen
  import ctr_ks_gen_pkg::*;
#(
  parameter int INC_WIDTH = INC_WIDTH_DEF,
  parameter bit PREFETCH  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ctr_load,
  input  logic [BLOCK_W-1:0] ctr_init,
  input  logic               ks_req,
  output logic               ks_valid,
  output logic [BLOCK_W-1:0] ks_data,
  input  logic               aes_ready,
  output logic               aes_start,
  output logic [BLOCK_W-1:0] aes_block,
  input  logic               aes_done,
  input  logic [BLOCK_W-1:0] aes_result,
  output logic               busy
);

  ctr_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] ctr_q, ctr_d;
  logic               epoch_q, epoch_d;
  logic               inflight_q, inflight_d;
  logic               inflight_tag_q, inflight_tag_d;
  logic               granted_q, granted_d;
  logic               ks_req_q;
  logic               aes_start_q, aes_start_d;
  logic [BLOCK_W-1:0] aes_block_q, aes_block_d;

  ks_slot_t slot0_s, slot1_s;
  logic     loaded_s;
  logic     issue_s;
  logic     result_ok_s;
  logic     retire_s;
  logic     grant_s;

  // Event decode. Issue is only decided with nothing in flight, so the slot
  // occupancy seen here already accounts for every pending result.
  always_comb begin
    loaded_s    = (state_q == ST_RUN);
    issue_s     = loaded_s && !ctr_load && !inflight_q && aes_ready &&
                  (!slot0_s.valid || (PREFETCH && !slot1_s.valid));
    result_ok_s = aes_done && inflight_q && (inflight_tag_q == epoch_q) && !ctr_load;
    retire_s    = loaded_s && !ctr_load && ks_req && !ks_req_q && granted_q;
    grant_s     = loaded_s && !ctr_load && ks_req && ks_req_q && slot0_s.valid;
  end

  // Next-state logic for run state, counter, epoch, in-flight tracking and grant.
  always_comb begin
    state_d        = state_q;
    ctr_d          = ctr_q;
    epoch_d        = epoch_q;
    inflight_d     = inflight_q;
    inflight_tag_d = inflight_tag_q;
    granted_d      = granted_q;
    aes_start_d    = 1'b0;
    aes_block_d    = aes_block_q;

    case (state_q)
      ST_UNLOADED: begin
        if (ctr_load) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_UNLOADED;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_UNLOADED;
    endcase

    if (ctr_load) begin
      ctr_d   = ctr_init;
      epoch_d = ~epoch_q;
    end else if (issue_s) begin
      ctr_d = inc32(ctr_q, INC_WIDTH);
    end else begin
      ctr_d = ctr_q;
    end

    // A result in the load cycle belongs to the old epoch; only the slot write is suppressed.
    if (issue_s) begin
      inflight_d     = 1'b1;
      inflight_tag_d = epoch_q;
      aes_start_d    = 1'b1;
      aes_block_d    = ctr_q;
    end else if (aes_done) begin
      inflight_d = 1'b0;
    end else begin
      inflight_d = inflight_q;
    end

    if (ctr_load || retire_s) begin
      granted_d = 1'b0;
    end else if (grant_s) begin
      granted_d = 1'b1;
    end else begin
      granted_d = granted_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_UNLOADED;
      ctr_q          <= '0;
      epoch_q        <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= 1'b0;
      granted_q      <= 1'b0;
      ks_req_q       <= 1'b0;
      aes_start_q    <= 1'b0;
      aes_block_q    <= '0;
    end else begin
      state_q        <= state_d;
      ctr_q          <= ctr_d;
      epoch_q        <= epoch_d;
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
      granted_q      <= granted_d;
      ks_req_q       <= ks_req;
      aes_start_q    <= aes_start_d;
      aes_block_q    <= aes_block_d;
    end
  end

  ctr_ks_gen_ks_slot_fifo u_slots (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (ctr_load),
    .push_i      (result_ok_s),
    .push_data_i (aes_result),
    .pop_i       (retire_s),
    .slot0_o     (slot0_s),
    .slot1_o     (slot1_s)
  );

  assign ks_valid  = slot0_s.valid;
  assign ks_data   = slot0_s.data;
  assign aes_start = aes_start_q;
  assign aes_block = aes_block_q;
  assign busy      = loaded_s && (inflight_q || !slot0_s.valid);

endmodule

// File: doc/ctr_ks_gen.md
Name: ctr_ks_gen

Overview:
- CTR keystream responder.
- Answers a payload XOR stage's level-type keystream request (ks_req / ks_valid / ks_data).
- Owns the 128-bit counter block and GCM inc32 stepping, issues counter blocks to an external AES block-cipher core, and buffers results in a 2-slot prefetch queue so a block is normally ready before it is requested.

Parameters:
- INC_WIDTH, 32, width of the low counter field incremented per block; the upper 128-INC_WIDTH bits are never modified.
- PREFETCH, 1, enables slot1 prefetch. 0 means encrypt strictly on demand.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ctr_load  input  1  single-cycle pulse: load ctr_init, flush all buffered and in-flight keystream
- ctr_init  input  128  first counter block to encrypt (caller supplies inc32(J0))
- ks_req  input  1  level request from the XOR stage
- ks_valid  output  1  registered; slot0 holds a presentable keystream block
- ks_data  output  128  registered; slot0 keystream, stable while ks_valid=1
- aes_ready  input  1  AES core can accept a block this cycle
- aes_start  output  1  registered single-cycle issue strobe (only when aes_ready=1)
- aes_block  output  128  counter block, valid with aes_start
- aes_done  input  1  result strobe from the AES core
- aes_result  input  128  E(K, counter), valid with aes_done
- busy  output  1  loaded and (AES in flight or slot0 empty)

Behaviour:
- Reset (async):
  - Outputs: ks_valid=0, ks_data=0, aes_start=0, aes_block=0, busy=0.
  - Internal: ctr=0, slots empty, loaded=0, inflight=0, granted=0, ks_req_q=0, epoch=0.
- Load:
  - ctr_load captures ctr_init into ctr and sets loaded=1.
  - It clears slot0, slot1 and granted, and toggles epoch.
  - An AES result that returns with a stale epoch tag is discarded.
  - ctr_load has priority over every other event in the same cycle.
- Issue rule, when loaded and not ctr_load:
  - Issue only if inflight=0 and aes_ready=1, and either slot0 is empty or (PREFETCH=1 and slot1 is empty), with the free slot counting results still pending.
  - On issue: aes_start=1 next cycle, aes_block=ctr, then ctr[INC_WIDTH-1:0] += 1 mod 2^INC_WIDTH. There is no carry into the upper bits; 0xFFFFFFFF wraps to 0x00000000.
  - One block in flight maximum; inflight carries the epoch tag.
- AES completion: on aes_done with a matching tag, the result is written to slot0 if it is empty, else to slot1. inflight clears.
- Request protocol:
  - ks_req_q is ks_req delayed by one cycle.
  - Grant: ks_req=1 and ks_req_q=1 and ks_valid=1 sets granted=1. This marks the block as taken by the XOR stage.
  - A granted block stays presented, with ks_valid=1 and ks_data unchanged, while ks_req=0. This holds for an unbounded number of cycles, covering downstream backpressure.
  - Retire: ks_req=1 and ks_req_q=0 and granted=1. Slot0 is dropped; slot1 (if valid) moves to slot0 at the same edge, otherwise slot0 becomes empty. granted clears.
  - ks_valid and ks_data reflect the new slot0 from the next cycle.
  - A rising ks_req with granted=0 does not retire.
- Simultaneous events:
  - Retire plus aes_done in the same cycle: the result lands in slot0 if slot1 was empty, else in slot1 after the shift. No loss, no duplication.
- Latency:
  - Prefetched block: ks_valid is already high when ks_req rises.
  - Empty queue: ks_valid=1 one cycle after aes_done.
- ks_req=1 before any load: ignored, and ks_valid stays 0.
- FSM, 2 states:
  - UNLOADED to RUN on ctr_load.
  - RUN to RUN on ctr_load (flush).
  - Only reset returns to UNLOADED.

Decomposition:
- Shared package:
  - BLOCK_W=128 and INC_WIDTH default.
  - inc32 function (low-field increment, upper bits preserved).
  - Keystream slot struct {valid, data}.
- Sub-module ks_slot_fifo: 2-entry shift queue with push, pop and simultaneous push/pop.
- The counter, issue logic, epoch handling and request protocol stay in the top module.

Test Plan:
- Load ctr_init=...0000_0002 with a fixed-latency AES model, then idle.
  - aes_block sequence ...0002, ...0003.
  - Both slots fill; no third issue.
  - ks_valid=1 before the first ks_req.
- Request cycle with ks_req=1 for 2 cycles, then 0 for 5 cycles:
  - ks_data = E(...0002) is held stable for all 5 low cycles.
  - The next ks_req rise shifts in E(...0003), and a refill issues ...0004.
- Load ctr_init low field = 0xFFFFFFFF with upper bits 0xCAFE...:
  - Issued blocks have low fields 0xFFFFFFFF, then 0x00000000.
  - Upper 96 bits unchanged.
- Pulse ctr_load while a block is in flight:
  - The stale aes_done result is discarded.
  - The first ks_data after reload equals E(new ctr_init).
- Hold aes_ready=0 for 10 cycles with a pending request:
  - aes_start=0, ks_valid=0, busy=1.
  - After aes_ready rises, ks_valid=1 one cycle after aes_done.
- Async rst_n low mid-transfer: all outputs 0 immediately, and ks_req is then ignored until ctr_load.
